// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types, sizes and key constants for the keypad scanner
package keypad_scanner_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int KEY_NUM  = 16;

    // Direction keys used by the vision test (index = row*4 + col)
    localparam logic [3:0] KEY_UP    = 4'd1;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } frame_cls_t;

    typedef struct packed {
        frame_cls_t cls;
        logic [3:0] idx;
    } frame_class_t;

    // Classify a full 16-key frame; idx is only meaningful for CLS_SINGLE
    function automatic frame_class_t classify(input logic [KEY_NUM-1:0] frame);
        frame_class_t res;
        int n;
        n       = 0;
        res.idx = 4'd0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (frame[i]) begin
                n++;
                res.idx = 4'(i);
            end
        end
        if (n == 0)
            res.cls = CLS_NONE;
        else if (n == 1)
            res.cls = CLS_SINGLE;
        else
            res.cls = CLS_MULTI;
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and decoded key signals
interface keypad_scanner_if;
    import keypad_scanner_pkg::*;

    logic [KEY_COLS-1:0] key_col;
    logic [KEY_ROWS-1:0] key_row;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_held;

    // scanner side
    modport master (
        input  key_col,
        output key_row,
        output key_code,
        output key_valid,
        output key_held
    );

    // keypad / consumer side
    modport slave (
        output key_col,
        input  key_row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// rtl/keypad_scanner_scan_tick_gen.sv - one-cycle tick every SCAN_DIV clocks
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [W-1:0] div;

    assign tick = (div == W'(SCAN_DIV - 1));

    // free-running divider, wraps on the tick cycle
    always_ff @(posedge clk) begin
        if (rst)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with per-frame debounce
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic                clk,
    input  logic                rst_n,   // active-high despite the name
    keypad_scanner_if.master    kp
);
    localparam logic [7:0] DF = 8'(DEBOUNCE_FRAMES);

    logic [3:0]         col_m;
    logic [3:0]         col_s;
    logic               tick;
    logic [1:0]         row;
    logic [3:0]         row_drv;
    logic [KEY_NUM-1:0] snapshot;
    logic [KEY_NUM-1:0] frame;
    logic               frame_end;
    frame_class_t       fc;
    state_t             state;
    logic [7:0]         cnt;
    logic [7:0]         cnt_inc;
    logic [3:0]         cand;
    logic [3:0]         code_r;
    logic               valid_r;
    logic               held_r;

    assign kp.key_row   = row_drv;
    assign kp.key_code  = code_r;
    assign kp.key_valid = valid_r;
    assign kp.key_held  = held_r;

    // two-flop synchronizer, inverted so 1 = pressed
    always_ff @(posedge clk) begin
        if (rst_n) begin
            col_m <= '0;
            col_s <= '0;
        end else begin
            col_m <= ~kp.key_col;
            col_s <= col_m;
        end
    end

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst_n),
        .tick (tick)
    );

    // latch the current row's columns and move the drive to the next row
    always_ff @(posedge clk) begin
        if (rst_n) begin
            row      <= 2'd0;
            row_drv  <= 4'b1110;
            snapshot <= '0;
        end else if (tick) begin
            snapshot[{row, 2'b00} +: 4] <= col_s;
            row     <= row + 2'd1;
            row_drv <= ~(4'b0001 << (row + 2'd1));
        end
    end

    // row 3 is still in col_s at frame end, so merge it in before classifying
    always_comb begin
        frame                     = snapshot;
        frame[{row, 2'b00} +: 4]  = col_s;
    end

    assign frame_end = tick && (row == 2'd3);
    assign fc        = classify(frame);
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // debounce FSM, evaluated once per frame; valid is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            cand    <= 4'd0;
            code_r  <= 4'd0;
            valid_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (fc.cls == CLS_SINGLE) begin
                            cand <= fc.idx;
                            cnt  <= 8'd1;
                            if (DF <= 8'd1) begin
                                code_r  <= fc.idx;
                                valid_r <= 1'b1;
                                held_r  <= 1'b1;
                                state   <= PRESSED;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (fc.cls == CLS_SINGLE) begin
                            if (fc.idx == cand) begin
                                cnt <= cnt_inc;
                                if (cnt_inc >= DF) begin
                                    code_r  <= cand;
                                    valid_r <= 1'b1;
                                    held_r  <= 1'b1;
                                    state   <= PRESSED;
                                end
                            end else begin
                                cand <= fc.idx;
                                cnt  <= 8'd1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        // extra keys while held are ignored; only a clean NONE starts release
                        if (fc.cls == CLS_NONE) begin
                            cnt <= 8'd1;
                            if (DF <= 8'd1) begin
                                held_r <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (fc.cls == CLS_NONE) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= DF) begin
                                held_r <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
